fp8_accumulator: RTL and testbench



---
 rtl/fp8_accumulator.sv | 223 ++++++++++++++++++++++
 tb/tb_fp8_accumulator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp8_accumulator.sv
// fp8_accumulator: adds a stream of 8-bit mini-float terms
// (s | eee bias 3 | mmmm with hidden 1) one at a time.
// Each term passes through an ALIGN, ADD, NORM sequence.
// After a term flagged last has been added, the sum is presented on the output side.
module fp8_accumulator #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_DONE
    } state_t;

    localparam logic [7:0] INF_CODE = 8'h70;

    state_t           state_q, state_d;
    logic [7:0]       term_q, term_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             inf_q, inf_d;
    logic [7:0]       acc_q, acc_d;

    // Aligned operands. The "big" operand has the larger magnitude and supplies the exponent and the sign.
    logic             big_sign_q, big_sign_d;
    logic [2:0]       big_exp_q, big_exp_d;
    logic [4:0]       big_sig_q, big_sig_d;
    logic             small_sign_q, small_sign_d;
    logic [4:0]       small_sig_q, small_sig_d;

    // Raw sum that is waiting for normalisation.
    logic             res_sign_q, res_sign_d;
    logic [2:0]       res_exp_q, res_exp_d;
    logic [5:0]       res_mag_q, res_mag_d;

    // ALIGN helpers
    logic             acc_zero, term_zero, term_bigger;
    logic [4:0]       acc_sig, term_sig, raw_small_sig;
    logic [2:0]       exp_diff;
    logic [2:0]       exp_inc;
    logic             norm_exit;

    // The ready signal is gated by reset, so no term can be accepted while reset is held.
    assign in_ready  = (state_q == S_WAIT) && rst_n;
    assign out_valid = (state_q == S_DONE);
    assign out_data  = acc_q;
    assign out_count = count_q;

    // State and datapath registers. Reset discards any term in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_WAIT;
            term_q       <= '0;
            last_q       <= 1'b0;
            count_q      <= '0;
            inf_q        <= 1'b0;
            acc_q        <= '0;
            big_sign_q   <= 1'b0;
            big_exp_q    <= '0;
            big_sig_q    <= '0;
            small_sign_q <= 1'b0;
            small_sig_q  <= '0;
            res_sign_q   <= 1'b0;
            res_exp_q    <= '0;
            res_mag_q    <= '0;
        end else begin
            state_q      <= state_d;
            term_q       <= term_d;
            last_q       <= last_d;
            count_q      <= count_d;
            inf_q        <= inf_d;
            acc_q        <= acc_d;
            big_sign_q   <= big_sign_d;
            big_exp_q    <= big_exp_d;
            big_sig_q    <= big_sig_d;
            small_sign_q <= small_sign_d;
            small_sig_q  <= small_sig_d;
            res_sign_q   <= res_sign_d;
            res_exp_q    <= res_exp_d;
            res_mag_q    <= res_mag_d;
        end
    end

    // Operand ordering and alignment. The magnitude order is {exp, mant}, so zero always sorts lowest.
    always_comb begin
        acc_zero    = (acc_q[6:0] == 7'd0);
        term_zero   = (term_q[6:0] == 7'd0);
        acc_sig     = acc_zero  ? 5'd0 : {1'b1, acc_q[3:0]};
        term_sig    = term_zero ? 5'd0 : {1'b1, term_q[3:0]};
        term_bigger = (term_q[6:0] > acc_q[6:0]);
        if (term_bigger) begin
            exp_diff      = term_q[6:4] - acc_q[6:4];
            raw_small_sig = acc_sig;
        end else begin
            exp_diff      = acc_q[6:4] - term_q[6:4];
            raw_small_sig = term_sig;
        end
    end

    // Next-state logic, datapath step per state, and batch bookkeeping.
    always_comb begin
        state_d      = state_q;
        term_d       = term_q;
        last_d       = last_q;
        count_d      = count_q;
        inf_d        = inf_q;
        acc_d        = acc_q;
        big_sign_d   = big_sign_q;
        big_exp_d    = big_exp_q;
        big_sig_d    = big_sig_q;
        small_sign_d = small_sign_q;
        small_sig_d  = small_sig_q;
        res_sign_d   = res_sign_q;
        res_exp_d    = res_exp_q;
        res_mag_d    = res_mag_q;
        exp_inc      = res_exp_q + 3'd1;
        norm_exit    = 1'b0;

        case (state_q)
            S_WAIT: begin
                if (in_valid && in_ready) begin
                    term_d = in_data;
                    last_d = in_last;
                    if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    // An overflow-marker input makes the rest of the batch saturate.
                    if (in_data[6:4] == 3'b111) begin
                        inf_d = 1'b1;
                    end
                    state_d = S_ALIGN;
                end
            end

            S_ALIGN: begin
                if (term_bigger) begin
                    big_sign_d   = term_q[7];
                    big_exp_d    = term_q[6:4];
                    big_sig_d    = term_sig;
                    small_sign_d = acc_q[7];
                end else begin
                    big_sign_d   = acc_q[7];
                    big_exp_d    = acc_q[6:4];
                    big_sig_d    = acc_sig;
                    small_sign_d = term_q[7];
                end
                // Bits shifted out are truncated. A shift of 5 or more clears the operand.
                small_sig_d = (exp_diff >= 3'd5) ? 5'd0 : (raw_small_sig >> exp_diff);
                state_d     = S_ADD;
            end

            S_ADD: begin
                res_sign_d = big_sign_q;
                res_exp_d  = big_exp_q;
                // A zero operand has significand 0, so the other operand passes through unchanged.
                if (small_sig_q == 5'd0) begin
                    res_mag_d = {1'b0, big_sig_q};
                end else if (big_sign_q == small_sign_q) begin
                    res_mag_d = {1'b0, big_sig_q} + {1'b0, small_sig_q};
                end else begin
                    res_mag_d = {1'b0, big_sig_q} - {1'b0, small_sig_q};
                end
                state_d = S_NORM;
            end

            S_NORM: begin
                norm_exit = 1'b1;
                if (inf_q) begin
                    acc_d = INF_CODE;
                end else if (res_mag_q[5]) begin
                    // Carry out of the add: shift right by one and increment the exponent.
                    if (exp_inc == 3'b111) begin
                        inf_d = 1'b1;
                        acc_d = INF_CODE;
                    end else begin
                        acc_d = {res_sign_q, exp_inc, res_mag_q[4:1]};
                    end
                end else if (res_mag_q[4]) begin
                    acc_d = {res_sign_q, res_exp_q, res_mag_q[3:0]};
                end else if (res_mag_q == 6'd0) begin
                    acc_d = 8'h00;
                end else if (res_exp_q == 3'd0) begin
                    // Another left shift would need exponent -1, so the result is flushed to zero.
                    acc_d = 8'h00;
                end else begin
                    norm_exit = 1'b0;
                    res_mag_d = {res_mag_q[4:0], 1'b0};
                    res_exp_d = res_exp_q - 3'd1;
                end
                if (norm_exit) begin
                    state_d = last_q ? S_DONE : S_WAIT;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    acc_d   = 8'h00;
                    count_d = '0;
                    inf_d   = 1'b0;
                    state_d = S_WAIT;
                end
            end

            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_fp8_accumulator.sv
// Directed bench for fp8_accumulator. Expected sums and latencies below were worked out by hand.
`timescale 1ns/1ps
module tb_fp8_accumulator;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_count;

    int n_cmp;
    int n_bad;

    fp8_accumulator #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit hit, required finish");
        $fatal(1, "watchdog");
    end

    // Presents one term and waits until it is accepted. It then counts clock edges until
    // in_ready or out_valid comes back. The task is called at a negedge and returns at a negedge.
    task automatic send_term(input logic [7:0] d, input logic l, output int cyc);
        int guard;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout term=%02h: in_ready=%0b, required 1", d, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end while (!(in_ready || out_valid) && cyc < 20);
        if (!(in_ready || out_valid)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout term=%02h: no ready/valid after %0d cycles", d, cyc);
        end
        $display("term %02h last=%0b -> %0d cycles, out_data=%02h", d, l, cyc, out_data);
    endtask

    // Completes the output handshake. This task drives signals only and performs no checks.
    task automatic pop_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0)   begin n_bad++; $display("FAIL reset_in_ready: got %0b, required 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00)  begin n_bad++; $display("FAIL reset_out_data: got %02h, required 00", out_data); end
        n_cmp++; if (out_count !== 4'd0)  begin n_bad++; $display("FAIL reset_out_count: got %0d, required 0", out_count); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1)   begin n_bad++; $display("FAIL post_reset_ready: got %0b, required 1", in_ready); end
        $display("reset checked");
    endtask

    // 0.75 + 0.3125 = 1.0625. The add carries out, so NORM takes a single cycle.
    task automatic test_carry();
        int c;
        send_term(8'h28, 1'b0, c);
        n_cmp++; if (c !== 3) begin n_bad++; $display("FAIL carry_first_lat: got %0d, required 3", c); end
        send_term(8'h14, 1'b1, c);
        n_cmp++; if (c !== 3)              begin n_bad++; $display("FAIL carry_lat: got %0d, required 3", c); end
        n_cmp++; if (out_valid !== 1'b1)   begin n_bad++; $display("FAIL carry_valid: got %0b, required 1", out_valid); end
        n_cmp++; if (out_data !== 8'h31)   begin n_bad++; $display("FAIL carry_data: got %02h, required 31", out_data); end
        n_cmp++; if (out_count !== 4'd2)   begin n_bad++; $display("FAIL carry_count: got %0d, required 2", out_count); end
        pop_result();
        n_cmp++; if (out_valid !== 1'b0)   begin n_bad++; $display("FAIL carry_valid_drop: got %0b, required 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00)   begin n_bad++; $display("FAIL carry_acc_clear: got %02h, required 00", out_data); end
        n_cmp++; if (out_count !== 4'd0)   begin n_bad++; $display("FAIL carry_cnt_clear: got %0d, required 0", out_count); end
    endtask

    // 1.0625 - 0.75 = 0.3125. This case needs two left shifts and then an exit, so NORM takes 3 cycles.
    task automatic test_cancel_norm();
        int c;
        send_term(8'h31, 1'b0, c);
        send_term(8'hA8, 1'b1, c);
        n_cmp++; if (c !== 5)              begin n_bad++; $display("FAIL cancel_lat: got %0d, required 5", c); end
        n_cmp++; if (out_data !== 8'h14)   begin n_bad++; $display("FAIL cancel_data: got %02h, required 14", out_data); end
        pop_result();
        // 0.3125 - 0.75 = -0.4375, which encodes as 1_001_1100. NORM takes 2 cycles here.
        send_term(8'h14, 1'b0, c);
        send_term(8'hA8, 1'b1, c);
        n_cmp++; if (c !== 4)              begin n_bad++; $display("FAIL negres_lat: got %0d, required 4", c); end
        n_cmp++; if (out_data !== 8'h9C)   begin n_bad++; $display("FAIL negres_data: got %02h, required 9C", out_data); end
        pop_result();
        // 2.0 + 0.2421875: the smaller operand is shifted by 4 and truncated to 00001, giving 10001 = 0x41.
        send_term(8'h40, 1'b0, c);
        send_term(8'h0F, 1'b1, c);
        n_cmp++; if (out_data !== 8'h41)   begin n_bad++; $display("FAIL trunc_data: got %02h, required 41", out_data); end
        pop_result();
    endtask

    task automatic test_exact_cancel();
        int c;
        send_term(8'h28, 1'b0, c);
        send_term(8'hA8, 1'b1, c);
        n_cmp++; if (out_data !== 8'h00)   begin n_bad++; $display("FAIL exact_cancel_data: got %02h, required 00", out_data); end
        n_cmp++; if (out_count !== 4'd2)   begin n_bad++; $display("FAIL exact_cancel_count: got %0d, required 2", out_count); end
        pop_result();
    endtask

    task automatic test_overflow();
        int c;
        send_term(8'h60, 1'b0, c);
        send_term(8'h60, 1'b1, c);
        n_cmp++; if (out_data !== 8'h70)   begin n_bad++; $display("FAIL ovf_data: got %02h, required 70", out_data); end
        pop_result();
        send_term(8'h70, 1'b0, c);
        send_term(8'h28, 1'b1, c);
        n_cmp++; if (out_data !== 8'h70)   begin n_bad++; $display("FAIL inf_sticky_data: got %02h, required 70", out_data); end
        pop_result();
        // The inf flag must have been cleared when the previous batch was popped.
        send_term(8'h28, 1'b1, c);
        n_cmp++; if (out_data !== 8'h28)   begin n_bad++; $display("FAIL inf_cleared_data: got %02h, required 28", out_data); end
        pop_result();
        // A lone exp-111 term that is also last comes out in canonical form.
        send_term(8'hF5, 1'b1, c);
        n_cmp++; if (out_data !== 8'h70)   begin n_bad++; $display("FAIL inf_canon_data: got %02h, required 70", out_data); end
        pop_result();
    endtask

    task automatic test_backpressure();
        int c;
        send_term(8'h31, 1'b1, c);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h14;
            in_last  = 1'b1;
            @(posedge clk);
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1)  begin n_bad++; $display("FAIL hold_valid[%0d]: got %0b, required 1", i, out_valid); end
            n_cmp++; if (out_data !== 8'h31)  begin n_bad++; $display("FAIL hold_data[%0d]: got %02h, required 31", i, out_data); end
            n_cmp++; if (out_count !== 4'd1)  begin n_bad++; $display("FAIL hold_count[%0d]: got %0d, required 1", i, out_count); end
            n_cmp++; if (in_ready !== 1'b0)   begin n_bad++; $display("FAIL hold_in_ready[%0d]: got %0b, required 0", i, in_ready); end
            $display("hold cycle %0d: out_valid=%0b out_data=%02h", i, out_valid, out_data);
        end
        in_valid = 1'b0;
        pop_result();
        send_term(8'h28, 1'b1, c);
        n_cmp++; if (out_data !== 8'h28)   begin n_bad++; $display("FAIL after_hold_data: got %02h, required 28", out_data); end
        n_cmp++; if (out_count !== 4'd1)   begin n_bad++; $display("FAIL after_hold_count: got %0d, required 1", out_count); end
        pop_result();
    endtask

    task automatic test_reset_midop();
        int c;
        send_term(8'h31, 1'b0, c);
        // Accept 0xA8 by hand so that reset can be applied while NORM is running.
        in_valid = 1'b1;
        in_data  = 8'hA8;
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0)    begin n_bad++; $display("FAIL midrst_in_ready: got %0b, required 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)   begin n_bad++; $display("FAIL midrst_out_valid: got %0b, required 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00)   begin n_bad++; $display("FAIL midrst_out_data: got %02h, required 00", out_data); end
        n_cmp++; if (out_count !== 4'd0)   begin n_bad++; $display("FAIL midrst_out_count: got %0d, required 0", out_count); end
        rst_n = 1'b1;
        @(negedge clk);
        send_term(8'h14, 1'b1, c);
        n_cmp++; if (out_data !== 8'h14)   begin n_bad++; $display("FAIL midrst_next_data: got %02h, required 14", out_data); end
        n_cmp++; if (out_count !== 4'd1)   begin n_bad++; $display("FAIL midrst_next_count: got %0d, required 1", out_count); end
        pop_result();
    endtask

    task automatic test_count_saturate();
        int c;
        for (int i = 0; i < 16; i++) begin
            send_term(8'h00, 1'b0, c);
        end
        send_term(8'h00, 1'b1, c);
        n_cmp++; if (out_count !== 4'd15)  begin n_bad++; $display("FAIL sat_count: got %0d, required 15", out_count); end
        n_cmp++; if (out_data !== 8'h00)   begin n_bad++; $display("FAIL sat_data: got %02h, required 00", out_data); end
        pop_result();
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_carry();
        test_cancel_norm();
        test_exact_cancel();
        test_overflow();
        test_backpressure();
        test_reset_midop();
        test_count_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
